// File: rtl/cv32e40p_ecc_pkg.sv
// Shared SEC-DED definitions for the register file: default widths, scrubber FSM states and
// the encode/syndrome helpers used by the RF write path.
package cv32e40p_ecc_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PAR_W  = 6;
  localparam int unsigned CW_W   = DATA_W + PAR_W + 1;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StCheck,
    StWb
  } scrub_state_e;

  // XOR of the Hamming positions (bit index + 1) of all set bits, overall parity excluded.
  function automatic logic [PAR_W-1:0] ecc_syndrome(input logic [CW_W-1:0] cw);
    logic [PAR_W-1:0] s;
    s = '0;
    for (int unsigned i = 0; i < CW_W - 1; i++) begin
      if (cw[i]) s ^= PAR_W'(i + 1);
    end
    return s;
  endfunction

  function automatic logic [CW_W-1:0] ecc_encode(input logic [DATA_W-1:0] data);
    logic [CW_W-1:0]  cw;
    logic [PAR_W-1:0] s;
    int unsigned      d;
    cw = '0;
    d  = 0;
    for (int unsigned i = 0; i < CW_W - 1; i++) begin
      if (((i + 1) & i) != 0) begin
        cw[i] = data[d];
        d++;
      end
    end
    // With parity slots still zero, syndrome bit k is exactly the parity owed at position 2^k.
    s = ecc_syndrome(cw);
    for (int unsigned k = 0; k < PAR_W; k++) begin
      cw[(2 ** k) - 1] = s[k];
    end
    cw[CW_W-1] = ^cw[CW_W-2:0];
    return cw;
  endfunction

endpackage

// File: rtl/cv32e40p_secded_decoder.sv
// Combinational SEC-DED decoder: extended Hamming syndrome plus overall parity.
module cv32e40p_secded_decoder #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PAR_W  = 6,
  parameter int unsigned CW_W   = DATA_W + PAR_W + 1
) (
  input  logic [CW_W-1:0] codeword,
  output logic [CW_W-1:0] corrected,
  output logic            single_err,
  output logic            double_err
);

  logic [PAR_W-1:0] syn;
  logic             par;

  always_comb begin
    syn = '0;
    for (int unsigned i = 0; i < CW_W - 1; i++) begin
      if (codeword[i]) syn ^= PAR_W'(i + 1);
    end
    par        = ^codeword;
    corrected  = codeword;
    single_err = 1'b0;
    double_err = 1'b0;
    if (par) begin
      if (syn == '0) begin
        corrected[CW_W-1] = ~codeword[CW_W-1];
        single_err        = 1'b1;
      end else if (32'(syn) <= CW_W - 1) begin
        corrected  = codeword ^ (CW_W'(1) << (syn - PAR_W'(1)));
        single_err = 1'b1;
      end else begin
        // Syndrome points past the codeword: odd error count >= 3.
        double_err = 1'b1;
      end
    end else if (syn != '0) begin
      double_err = 1'b1;
    end
  end

endmodule

// File: rtl/cv32e40p_rf_ecc_scrubber.sv
// Background RF scrubber: periodically reads one register, corrects single errors by
// write-back, logs double errors and counts corrections.
module cv32e40p_rf_ecc_scrubber
  import cv32e40p_ecc_pkg::*;
#(
  parameter int unsigned DATA_W         = cv32e40p_ecc_pkg::DATA_W,
  parameter int unsigned PAR_W          = cv32e40p_ecc_pkg::PAR_W,
  parameter int unsigned CW_W           = DATA_W + PAR_W + 1,
  parameter int unsigned NUM_REGS       = 32,
  parameter int unsigned START_ADDR     = 1,
  parameter int unsigned SCRUB_INTERVAL = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable_i,
  input  logic                        clear_i,
  output logic                        rf_rreq_o,
  output logic [$clog2(NUM_REGS)-1:0] rf_raddr_o,
  input  logic                        rf_rgnt_i,
  input  logic [CW_W-1:0]             rf_rdata_i,
  output logic                        rf_we_o,
  output logic [$clog2(NUM_REGS)-1:0] rf_waddr_o,
  output logic [CW_W-1:0]             rf_wdata_o,
  input  logic                        rf_wgnt_i,
  input  logic                        core_we_i,
  input  logic [$clog2(NUM_REGS)-1:0] core_waddr_i,
  output logic [CNT_W-1:0]            corr_cnt_o,
  output logic                        uncorr_o,
  output logic [$clog2(NUM_REGS)-1:0] uncorr_addr_o
);

  localparam int unsigned     ADDR_W     = $clog2(NUM_REGS);
  localparam int unsigned     IVL_W      = $clog2(SCRUB_INTERVAL) + 1;
  localparam logic [IVL_W-1:0] IVL_RELOAD = IVL_W'(SCRUB_INTERVAL - 1);
  localparam logic [ADDR_W-1:0] FIRST     = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  if ((2 ** PAR_W) < DATA_W + PAR_W + 1) begin : gen_par_w_chk
    $error("PAR_W too small for DATA_W");
  end
  if (CW_W != DATA_W + PAR_W + 1) begin : gen_cw_w_chk
    $error("CW_W must equal DATA_W + PAR_W + 1");
  end
  if (SCRUB_INTERVAL < 1) begin : gen_ivl_chk
    $error("SCRUB_INTERVAL must be >= 1");
  end

  scrub_state_e      state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [IVL_W-1:0]  ivl_q, ivl_d;
  logic [CW_W-1:0]   cw_q, cw_d;
  logic              stale_q, stale_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              uncorr_q, uncorr_d;
  logic [ADDR_W-1:0] uaddr_q, uaddr_d;
  logic              rreq_q, we_q;
  logic [ADDR_W-1:0] raddr_q, waddr_q;
  logic [CW_W-1:0]   wdata_q;
  logic [CW_W-1:0]   corrected;
  logic              single_err, double_err;
  logic              hit, stale_now, advance;

  cv32e40p_secded_decoder #(
    .DATA_W (DATA_W),
    .PAR_W  (PAR_W),
    .CW_W   (CW_W)
  ) u_decoder (
    .codeword   (cw_q),
    .corrected  (corrected),
    .single_err (single_err),
    .double_err (double_err)
  );

  // A core write to the address in flight makes the scrubbed copy obsolete.
  assign hit       = core_we_i && (core_waddr_i == ptr_q);
  assign stale_now = stale_q | hit;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    ivl_d    = ivl_q;
    cw_d     = cw_q;
    stale_d  = stale_q;
    cnt_d    = cnt_q;
    uncorr_d = uncorr_q;
    uaddr_d  = uaddr_q;
    advance  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable_i) begin
          if (ivl_q == '0) begin
            state_d = StReq;
            ivl_d   = IVL_RELOAD;
          end else begin
            ivl_d = ivl_q - IVL_W'(1);
          end
        end
      end
      StReq: begin
        if (rf_rgnt_i) begin
          state_d = StWait;
          stale_d = hit;
        end
      end
      StWait: begin
        cw_d    = rf_rdata_i;
        stale_d = stale_now;
        state_d = StCheck;
      end
      StCheck: begin
        if (stale_now) begin
          advance = 1'b1;
        end else if (single_err) begin
          state_d = StWb;
        end else begin
          if (double_err && !uncorr_q) begin
            uncorr_d = 1'b1;
            uaddr_d  = ptr_q;
          end
          advance = 1'b1;
        end
      end
      StWb: begin
        if (stale_now) begin
          advance = 1'b1;
        end else if (rf_wgnt_i) begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          advance = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (advance) begin
      state_d = StIdle;
      ptr_d   = (ptr_q == LAST) ? FIRST : ptr_q + ADDR_W'(1);
      stale_d = 1'b0;
    end
    if (clear_i) begin
      cnt_d    = '0;
      uncorr_d = 1'b0;
      uaddr_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= FIRST;
      ivl_q    <= IVL_RELOAD;
      cw_q     <= '0;
      stale_q  <= 1'b0;
      cnt_q    <= '0;
      uncorr_q <= 1'b0;
      uaddr_q  <= '0;
      rreq_q   <= 1'b0;
      raddr_q  <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      ivl_q    <= ivl_d;
      cw_q     <= cw_d;
      stale_q  <= stale_d;
      cnt_q    <= cnt_d;
      uncorr_q <= uncorr_d;
      uaddr_q  <= uaddr_d;
      rreq_q   <= (state_d == StReq);
      raddr_q  <= (state_d == StReq) ? ptr_d : '0;
      we_q     <= (state_d == StWb);
      waddr_q  <= (state_d == StWb) ? ptr_d : '0;
      wdata_q  <= (state_d == StWb) ? corrected : '0;
    end
  end

  assign rf_rreq_o     = rreq_q;
  assign rf_raddr_o    = raddr_q;
  assign rf_we_o       = we_q;
  assign rf_waddr_o    = waddr_q;
  assign rf_wdata_o    = wdata_q;
  assign corr_cnt_o    = cnt_q;
  assign uncorr_o      = uncorr_q;
  assign uncorr_addr_o = uaddr_q;

endmodule

// File: tb/tb_cv32e40p_rf_ecc_scrubber.sv
// Bench acting as the RF and its arbiter; a brute-force SEC-DED model predicts every scrub.
module tb_cv32e40p_rf_ecc_scrubber;

  localparam int DW   = 32;
  localparam int CW   = 39;
  localparam int NR   = 32;
  localparam int AW   = 5;
  localparam int IVL  = 4;
  localparam int CNTW = 4;
  localparam int CMAX = (1 << CNTW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable_i = 1'b0;
  logic          clear_i = 1'b0;
  logic          rf_rgnt_i = 1'b0;
  logic          rf_wgnt_i = 1'b0;
  logic          core_we_i = 1'b0;
  logic [AW-1:0] core_waddr_i = '0;
  logic [CW-1:0] rf_rdata_i = '0;
  logic          rf_rreq_o, rf_we_o, uncorr_o;
  logic [AW-1:0] rf_raddr_o, rf_waddr_o, uncorr_addr_o;
  logic [CW-1:0] rf_wdata_o;
  logic [CNTW-1:0] corr_cnt_o;

  always #5 clk = ~clk;

  cv32e40p_rf_ecc_scrubber #(
    .DATA_W         (DW),
    .PAR_W          (6),
    .CW_W           (CW),
    .NUM_REGS       (NR),
    .START_ADDR     (1),
    .SCRUB_INTERVAL (IVL),
    .CNT_W          (CNTW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (enable_i),
    .clear_i       (clear_i),
    .rf_rreq_o     (rf_rreq_o),
    .rf_raddr_o    (rf_raddr_o),
    .rf_rgnt_i     (rf_rgnt_i),
    .rf_rdata_i    (rf_rdata_i),
    .rf_we_o       (rf_we_o),
    .rf_waddr_o    (rf_waddr_o),
    .rf_wdata_o    (rf_wdata_o),
    .rf_wgnt_i     (rf_wgnt_i),
    .core_we_i     (core_we_i),
    .core_waddr_i  (core_waddr_i),
    .corr_cnt_o    (corr_cnt_o),
    .uncorr_o      (uncorr_o),
    .uncorr_addr_o (uncorr_addr_o)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: RF contents plus expected scrubber-visible state.
  logic [CW-1:0] mem [NR];
  int exp_ptr = 1;
  int exp_cnt = 0;
  bit exp_unc = 1'b0;
  int exp_uaddr = 0;

  function automatic logic [CW-1:0] enc(input logic [DW-1:0] d);
    logic [CW-1:0] c;
    int k;
    logic x;
    c = '0;
    k = 0;
    for (int p = 1; p < CW; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 6; b++) begin
      x = 1'b0;
      for (int p = 1; p < CW; p++) begin
        if ((p & (p - 1)) != 0 && ((p >> b) & 1) != 0) x ^= c[p-1];
      end
      c[(1 << b) - 1] = x;
    end
    c[CW-1] = ^c[CW-2:0];
    return c;
  endfunction

  function automatic logic [DW-1:0] extract(input logic [CW-1:0] c);
    logic [DW-1:0] d;
    int k;
    d = '0;
    k = 0;
    for (int p = 1; p < CW; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = c[p-1];
        k++;
      end
    end
    return d;
  endfunction

  // 0 clean, 1 single (fixed = nearest codeword), 2 uncorrectable.
  function automatic int classify(input logic [CW-1:0] c, output logic [CW-1:0] fixed);
    logic [CW-1:0] t;
    fixed = c;
    if (enc(extract(c)) == c) return 0;
    for (int b = 0; b < CW; b++) begin
      t = c ^ (CW'(1) << b);
      if (enc(extract(t)) == t) begin
        fixed = t;
        return 1;
      end
    end
    return 2;
  endfunction

  function automatic logic [CW-1:0] rand_word();
    logic [CW-1:0] c;
    int n;
    c = enc($urandom);
    n = $urandom_range(0, 4);
    if (n == 4) c = CW'({$urandom, $urandom});
    else for (int i = 0; i < n; i++) c[$urandom_range(0, CW - 1)] ^= 1'b1;
    return c;
  endfunction

  task automatic core_write(input int a);
    core_we_i    = 1'b1;
    core_waddr_i = AW'(a);
    mem[a]       = enc($urandom);
  endtask

  // stale_mode: 0 none, 1 core hit during WB, 2 hit in WAIT, 3 hit in grant cycle,
  // 4 hit in the write-grant cycle.
  task automatic scrub_one(input int rdly, input int wdly, input int stale_mode,
                           input bit clr_wb, input bit drop_en, input bit rst_wb);
    logic [CW-1:0] word, fixed;
    int kind, waited, oa;
    bit exp_we, cancel;
    word   = mem[exp_ptr];
    kind   = classify(word, fixed);
    waited = 0;
    while (!rf_rreq_o && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    check_eq("rreq_seen", rf_rreq_o, 1);
    if (!rf_rreq_o) return;
    check_eq("raddr", rf_raddr_o, exp_ptr);
    repeat (rdly) begin @(posedge clk); #1; end
    if (rdly > 0) begin
      check_eq("rreq_hold", rf_rreq_o, 1);
      check_eq("raddr_hold", rf_raddr_o, exp_ptr);
    end
    rf_rgnt_i = 1'b1;
    if (stale_mode == 3) core_write(exp_ptr);
    @(posedge clk); #1;
    rf_rgnt_i  = 1'b0;
    core_we_i  = 1'b0;
    rf_rdata_i = word;
    check_eq("rreq_drop", rf_rreq_o, 0);
    if (drop_en) enable_i = 1'b0;
    if (stale_mode == 2) core_write(exp_ptr);
    else if ($urandom_range(0, 1) == 1) begin
      oa = $urandom_range(1, NR - 1);
      if (oa != exp_ptr) core_write(oa);
    end
    @(posedge clk); #1;
    core_we_i  = 1'b0;
    rf_rdata_i = CW'({$urandom, $urandom});
    check_eq("we_early", rf_we_o, 0);
    @(posedge clk); #1;
    exp_we = (kind == 1) && (stale_mode != 2) && (stale_mode != 3);
    check_eq("we", rf_we_o, exp_we);
    if (exp_we) begin
      check_eq("waddr", rf_waddr_o, exp_ptr);
      check_eq("wdata", rf_wdata_o, fixed);
      if (rst_wb) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_eq("rst_we", rf_we_o, 0);
        check_eq("rst_wdata", rf_wdata_o, 0);
        check_eq("rst_cnt", corr_cnt_o, 0);
        check_eq("rst_unc", uncorr_o, 0);
        exp_ptr = 1;
        exp_cnt = 0;
        exp_unc = 1'b0;
        exp_uaddr = 0;
        return;
      end
      cancel = 1'b0;
      for (int i = 0; i < wdly; i++) begin
        if (stale_mode == 1 && i == 0) core_write(exp_ptr);
        @(posedge clk); #1;
        core_we_i = 1'b0;
        if (stale_mode == 1) begin
          cancel = 1'b1;
          break;
        end
        check_eq("we_hold", rf_we_o, 1);
        check_eq("wdata_hold", rf_wdata_o, fixed);
      end
      if (!cancel) begin
        rf_wgnt_i = 1'b1;
        clear_i   = clr_wb;
        if (stale_mode == 4) core_write(exp_ptr);
        @(posedge clk); #1;
        rf_wgnt_i = 1'b0;
        clear_i   = 1'b0;
        core_we_i = 1'b0;
        cancel    = (stale_mode == 4);
        if (clr_wb) begin
          exp_cnt = 0;
          exp_unc = 1'b0;
          exp_uaddr = 0;
        end else if (!cancel && exp_cnt != CMAX) exp_cnt++;
        if (!cancel) mem[exp_ptr] = fixed;
      end
      check_eq("we_done", rf_we_o, 0);
    end else if (kind == 2 && stale_mode != 2 && stale_mode != 3 && !exp_unc) begin
      exp_unc = 1'b1;
      exp_uaddr = exp_ptr;
    end
    check_eq("corr_cnt", corr_cnt_o, exp_cnt);
    check_eq("uncorr", uncorr_o, exp_unc);
    check_eq("uncorr_addr", uncorr_addr_o, exp_uaddr);
    exp_ptr = (exp_ptr == NR - 1) ? 1 : exp_ptr + 1;
  endtask

  initial begin
    logic [CW-1:0] w;
    int lat;
    bit quiet;
    int rd, wd, sm;
    bit ce, de;

    for (int a = 0; a < NR; a++) mem[a] = rand_word();
    mem[1] = enc(32'hDEADBEEF);
    w = enc(32'h0);
    w[2] = ~w[2];
    mem[2] = w;
    w = '0;
    w[CW-1] = 1'b1;
    mem[3] = w;
    mem[4] = enc(32'h12345678);
    mem[5] = enc(32'h0) ^ CW'(3);
    mem[7] = enc(32'hCAFEF00D) ^ CW'(3);
    mem[9] = enc(32'h0000FFFF) ^ (CW'(1) << 10);
    for (int a = 12; a <= 16; a++) mem[a] = enc($urandom) ^ (CW'(1) << $urandom_range(0, CW - 1));
    mem[17] = CW'(39'h8000000C);
    mem[31] = enc(32'h0F0F0F0F);

    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_rreq", rf_rreq_o, 0);
    check_eq("reset_raddr", rf_raddr_o, 0);
    check_eq("reset_we", rf_we_o, 0);
    check_eq("reset_waddr", rf_waddr_o, 0);
    check_eq("reset_wdata", rf_wdata_o, 0);
    check_eq("reset_cnt", corr_cnt_o, 0);
    check_eq("reset_unc", uncorr_o, 0);
    check_eq("reset_uaddr", uncorr_addr_o, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("idle_no_req", rf_rreq_o, 0);

    enable_i = 1'b1;
    lat = 0;
    while (!rf_rreq_o && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("first_req_latency", lat, IVL);

    for (int a = 1; a < NR; a++) begin
      rd = 0; wd = 0; sm = 0; ce = 1'b0; de = 1'b0;
      case (a)
        4:  de = 1'b1;
        9:  begin wd = 3; sm = 1; end
        12: wd = 2;
        13: sm = 2;
        14: sm = 3;
        15: sm = 4;
        16: ce = 1'b1;
        31: rd = 10;
        default: ;
      endcase
      scrub_one(rd, wd, sm, ce, de, 1'b0);
      if (de) begin
        quiet = 1'b1;
        repeat (10) begin
          @(posedge clk); #1;
          if (rf_rreq_o) quiet = 1'b0;
        end
        check_eq("idle_when_disabled", quiet, 1);
        enable_i = 1'b1;
        lat = 0;
        while (!rf_rreq_o && lat < 50) begin
          @(posedge clk); #1;
          lat++;
        end
        check_eq("reenable_latency", lat, IVL);
      end
    end

    for (int n = 0; n < 60; n++) begin
      mem[exp_ptr] = rand_word();
      sm = $urandom_range(0, 9);
      if (sm > 4) sm = 0;
      scrub_one($urandom_range(0, 3), $urandom_range(0, 3), sm,
                $urandom_range(0, 15) == 0, 1'b0, 1'b0);
    end

    mem[exp_ptr] = enc(32'h0) ^ CW'(5);
    scrub_one(0, 0, 0, 1'b0, 1'b0, 1'b0);
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    exp_cnt = 0;
    exp_unc = 1'b0;
    exp_uaddr = 0;
    check_eq("clear_cnt", corr_cnt_o, exp_cnt);
    check_eq("clear_unc", uncorr_o, exp_unc);
    check_eq("clear_uaddr", uncorr_addr_o, exp_uaddr);

    mem[exp_ptr] = enc($urandom) ^ (CW'(1) << 7);
    scrub_one(0, 0, 0, 1'b0, 1'b0, 1'b1);
    mem[1] = enc(32'hA5A5A5A5) ^ (CW'(1) << 20);
    scrub_one(0, 1, 0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
